servo_pulse_decoder: RTL

- Receive side of the wheel-servo PWM link: decodes a servo-style pulse train, such as the wheel_signal outputs on JD, back into the 6-bit speed code that produced it.
- Measures high time and rise-to-rise period in microseconds, maps high time to speed, and flags malformed or missing signals.
- Used as an on-board loopback monitor for the wheel drive, and as a self-checking monitor in the nexys benches.

---
 rtl/servo_pulse_decoder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
// Receive side of the wheel-servo PWM link. Measures the high time and the
// rise-to-rise period of a servo pulse train in microseconds, maps the high
// time back to the 6-bit speed code, and flags glitches, stuck-high inputs
// and loss of signal.
//
// Ports:
//   clk_in        system clock (CLKS_PER_US cycles per microsecond)
//   rst_n_in      synchronous active-low reset
//   pwm_in        asynchronous servo pulse input
//   speed_out     decoded speed code (held between strobes)
//   width_us_out  last accepted high time in us (held between strobes)
//   period_us_out rise-to-rise interval ending at that pulse's rise, 0 if unknown
//   valid_out     one-cycle strobe, data outputs update in the same cycle
//   signal_ok_out pulse train present and well formed
//   error_out     one-cycle strobe on glitch or stuck-high
module servo_pulse_decoder #(
    parameter int CLKS_PER_US  = 100,
    parameter int MIN_US       = 1000,
    parameter int SPEED_SHIFT  = 4,
    parameter int INVERT       = 0,
    parameter int MIN_PULSE_US = 200,
    parameter int MAX_HIGH_US  = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        pwm_in,
    output logic [5:0]  speed_out,
    output logic [11:0] width_us_out,
    output logic [15:0] period_us_out,
    output logic        valid_out,
    output logic        signal_ok_out,
    output logic        error_out
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
    localparam logic [11:0]   MIN_W      = 12'(MIN_US);
    localparam logic [11:0]   MIN_PULSE  = 12'(MIN_PULSE_US);
    localparam logic [11:0]   MAX_HIGH   = 12'(MAX_HIGH_US);
    localparam logic [15:0]   TIMEOUT    = 16'(TIMEOUT_US);

    typedef enum logic [1:0] {
        SYNC_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } state_t;

    // High time (us) to speed code: offset, scale, saturate, optional mirror.
    function automatic logic [5:0] map_speed(input logic [11:0] w);
        logic [11:0] d;
        logic [11:0] s;
        d = (w < MIN_W) ? 12'd0 : (w - MIN_W);
        s = d >> SPEED_SHIFT;
        if (s > 12'd63) begin
            s = 12'd63;
        end
        if (INVERT != 0) begin
            return 6'd63 - s[5:0];
        end else begin
            return s[5:0];
        end
    endfunction

    logic          s1_q, s2_q, s3_q;
    logic [1:0]    fill_q;
    logic [PW-1:0] presc_q;
    state_t        state_q, state_d;
    logic [11:0]   hi_q, hi_d;
    logic [15:0]   per_q, per_d;
    logic [15:0]   prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic [5:0]    speed_q, speed_d;
    logic [11:0]   width_q, width_d;
    logic [15:0]   period_q, period_d;
    logic          valid_q, valid_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;

    logic          rise_s, fall_s, tick_s;
    logic [11:0]   hi_inc_s;
    logic [15:0]   per_inc_s;
    logic [15:0]   low_us_s;

    assign rise_s = s2_q & ~s3_q;
    assign fall_s = ~s2_q & s3_q;
    assign tick_s = (presc_q == PRESC_LAST);

    // Counts including this cycle's tick, so a measurement closing on a tick
    // edge still sees it (recorded time = floor(clocks / CLKS_PER_US)).
    assign hi_inc_s  = (tick_s && (hi_q != 12'hFFF)) ? (hi_q + 12'd1) : hi_q;
    assign per_inc_s = (tick_s && (per_q != 16'hFFFF)) ? (per_q + 16'd1) : per_q;
    assign low_us_s  = per_inc_s - {4'd0, width_q};

    // Synchronizer, edge history, pipeline-fill tracker and microsecond prescaler.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            fill_q  <= 2'd0;
            presc_q <= '0;
        end else begin
            s1_q    <= pwm_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            // s2 only holds a real pwm_in sample two edges after reset release.
            fill_q  <= (fill_q == 2'd2) ? 2'd2 : (fill_q + 2'd1);
            if (rise_s || fall_s || tick_s) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // FSM state and measurement/output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= SYNC_LOW;
            hi_q        <= 12'd0;
            per_q       <= 16'd0;
            prev_q      <= 16'd0;
            have_prev_q <= 1'b0;
            speed_q     <= 6'd0;
            width_q     <= 12'd0;
            period_q    <= 16'd0;
            valid_q     <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            per_q       <= per_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            speed_q     <= speed_d;
            width_q     <= width_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
        end
    end

    // Next-state and measurement decisions.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        per_d       = per_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        speed_d     = speed_q;
        width_d     = width_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        ok_d        = ok_q;
        err_d       = 1'b0;
        case (state_q)
            SYNC_LOW: begin
                // A pulse already high here is skipped until a real low is seen.
                have_prev_d = 1'b0;
                if ((fill_q == 2'd2) && !s2_q) begin
                    state_d = WAIT_RISE;
                end else begin
                    state_d = SYNC_LOW;
                end
            end
            WAIT_RISE: begin
                have_prev_d = 1'b0;
                if (rise_s) begin
                    hi_d    = 12'd0;
                    per_d   = 16'd0;
                    state_d = HIGH;
                end else begin
                    state_d = WAIT_RISE;
                end
            end
            HIGH: begin
                hi_d  = hi_inc_s;
                per_d = per_inc_s;
                // Stuck-high wins over a fall landing in the same cycle.
                if (hi_inc_s >= MAX_HIGH) begin
                    err_d       = 1'b1;
                    ok_d        = 1'b0;
                    have_prev_d = 1'b0;
                    state_d     = SYNC_LOW;
                end else if (fall_s) begin
                    if (hi_inc_s < MIN_PULSE) begin
                        err_d       = 1'b1;
                        ok_d        = 1'b0;
                        have_prev_d = 1'b0;
                        state_d     = WAIT_RISE;
                    end else begin
                        valid_d  = 1'b1;
                        width_d  = hi_inc_s;
                        period_d = have_prev_q ? prev_q : 16'd0;
                        speed_d  = map_speed(hi_inc_s);
                        ok_d     = 1'b1;
                        state_d  = LOW;
                    end
                end else begin
                    state_d = HIGH;
                end
            end
            LOW: begin
                per_d = per_inc_s;
                // A rise beats a timeout landing in the same cycle.
                if (rise_s) begin
                    prev_d      = per_inc_s;
                    have_prev_d = 1'b1;
                    hi_d        = 12'd0;
                    per_d       = 16'd0;
                    state_d     = HIGH;
                end else if (low_us_s >= TIMEOUT) begin
                    ok_d        = 1'b0;
                    have_prev_d = 1'b0;
                    state_d     = WAIT_RISE;
                end else begin
                    state_d = LOW;
                end
            end
            default: begin
                state_d = SYNC_LOW;
            end
        endcase
    end

    assign speed_out     = speed_q;
    assign width_us_out  = width_q;
    assign period_us_out = period_q;
    assign valid_out     = valid_q;
    assign signal_ok_out = ok_q;
    assign error_out     = err_q;

endmodule
